// File: rtl/keypad_event_if.sv
// rtl/keypad_event_if.sv - device-slot bus between the bridge and keypad_event
`timescale 1ns/1ps
interface keypad_event_if;
  logic [2:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  modport master (output addr, output we, output din, input dout, input irq);
  modport slave  (input addr, input we, input din, output dout, output irq);
endinterface

// File: rtl/keypad_event.sv
// rtl/keypad_event.sv - debounced keypad with sticky event flags, event counter and masked irq
`timescale 1ns/1ps
module keypad_event #(
  parameter int NKEYS           = 8,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] user_key,
  keypad_event_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NKEYS-1:0] s1_q, s2_q;
  logic [NKEYS-1:0] lvl_q, lvl_d, lvl_prev_q;
  logic [CNT_W-1:0] cnt_q [NKEYS];
  logic [CNT_W-1:0] cnt_d [NKEYS];
  logic [NKEYS-1:0] pend_q, pend_d;
  logic [NKEYS-1:0] mask_q, mask_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [15:0]      count_q, count_d;
  logic             irq_q;

  logic [NKEYS-1:0] rec;
  logic [3:0]       rec_cnt;
  logic             wr_pend, wr_mask, wr_ctrl, wr_count;
  logic             unused_din;

  assign wr_pend  = bus.we && (bus.addr == 3'd1);
  assign wr_mask  = bus.we && (bus.addr == 3'd2);
  assign wr_ctrl  = bus.we && (bus.addr == 3'd3);
  assign wr_count = bus.we && (bus.addr == 3'd4);
  assign unused_din = ^bus.din[31:NKEYS];

  // Two-flop synchroniser on the inverted keys so that 1 means pressed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= ~user_key;
      s2_q <= s1_q;
    end
  end

  // Debounce: the level flips only after s2 disagrees for DEBOUNCE_CYCLES edges in a row
  always_comb begin
    lvl_d = lvl_q;
    for (int k = 0; k < NKEYS; k++) begin
      cnt_d[k] = '0;
      if (s2_q[k] != lvl_q[k]) begin
        if (cnt_q[k] == CNT_LAST) lvl_d[k] = s2_q[k];
        else                      cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  // Debounce state and previous level used for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      for (int k = 0; k < NKEYS; k++) cnt_q[k] <= '0;
    end else begin
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
      for (int k = 0; k < NKEYS; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  // Recorded events: press/release edges gated by CTRL, plus how many occurred
  always_comb begin
    rec = ((lvl_q & ~lvl_prev_q) & {NKEYS{ctrl_q[0]}}) |
          ((~lvl_q & lvl_prev_q) & {NKEYS{ctrl_q[1]}});
    rec_cnt = '0;
    for (int k = 0; k < NKEYS; k++) rec_cnt = rec_cnt + 4'(rec[k]);
  end

  // Register next-state: a new event beats a same-cycle W1C, a COUNT write beats increments
  always_comb begin
    pend_d  = (pend_q & ~(wr_pend ? bus.din[NKEYS-1:0] : '0)) | rec;
    mask_d  = wr_mask ? bus.din[NKEYS-1:0] : mask_q;
    ctrl_d  = wr_ctrl ? bus.din[1:0] : ctrl_q;
    count_d = wr_count ? 16'h0 : count_q + 16'(rec_cnt);
  end

  // Software-visible registers and the registered interrupt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q  <= '0;
      mask_q  <= '0;
      ctrl_q  <= '0;
      count_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      irq_q   <= |(pend_q & mask_q);
    end
  end

  // Combinational read mux; unmapped addresses read zero
  always_comb begin
    bus.dout = '0;
    case (bus.addr)
      3'd0:    bus.dout = 32'(lvl_q);
      3'd1:    bus.dout = 32'(pend_q);
      3'd2:    bus.dout = 32'(mask_q);
      3'd3:    bus.dout = 32'(ctrl_q);
      3'd4:    bus.dout = 32'(count_q);
      default: bus.dout = '0;
    endcase
  end

  assign bus.irq = irq_q;

endmodule
